// File: rtl/aes_inv_key_schedule_if.sv
// Handshake/bus bundle between the inverse AES-128 key schedule and its consumer.
interface aes_inv_key_schedule_if;
    logic [127:0] key_in;
    logic         key_load;
    logic         busy;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] round_key;
    logic [3:0]   round_num;
    logic         last;

    modport master (
        output key_in, key_load, rk_ready,
        input  busy, rk_valid, round_key, round_num, last
    );

    modport slave (
        input  key_in, key_load, rk_ready,
        output busy, rk_valid, round_key, round_num, last
    );
endinterface

// File: rtl/aes_inv_key_schedule.sv
// AES-128 key schedule emitting round keys 10 down to 0: forward-expand once,
// then walk back one key per handshake holding only the current round key.

module g_func_key_expansion (
    input  logic [31:0] word_i,
    input  logic [3:0]  count_i,
    output logic [31:0] g_c_o
);
    localparam logic [7:0] SBOX [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    logic [31:0] rot_c;
    logic [7:0]  rcon_c;

    // RotWord, SubWord, then Rcon[count+1] into the top byte
    always_comb begin
        rot_c = {word_i[23:0], word_i[31:24]};
        case (count_i)
            4'd0:    rcon_c = 8'h01;
            4'd1:    rcon_c = 8'h02;
            4'd2:    rcon_c = 8'h04;
            4'd3:    rcon_c = 8'h08;
            4'd4:    rcon_c = 8'h10;
            4'd5:    rcon_c = 8'h20;
            4'd6:    rcon_c = 8'h40;
            4'd7:    rcon_c = 8'h80;
            4'd8:    rcon_c = 8'h1b;
            4'd9:    rcon_c = 8'h36;
            default: rcon_c = 8'h00;
        endcase
        g_c_o = {SBOX[rot_c[31:24]], SBOX[rot_c[23:16]], SBOX[rot_c[15:8]], SBOX[rot_c[7:0]]}
              ^ {rcon_c, 24'h0};
    end
endmodule

module aes_inv_key_schedule (
    input  logic                  clk,
    input  logic                  n_rst,
    aes_inv_key_schedule_if.slave bus
);
    localparam int unsigned KEY_W      = 128;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned CNT_W      = 4;
    localparam int unsigned LAST_CNT   = 9;
    localparam int unsigned NUM_ROUNDS = 10;

    typedef enum logic [1:0] {IDLE, EXPAND, EMIT} state_e;

    state_e             state_q, state_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   rnum_q, rnum_d;
    logic               busy_q, busy_d;
    logic               valid_q, valid_d;
    logic               last_q, last_d;

    logic [WORD_W-1:0]  w0, w1, w2, w3;
    logic [WORD_W-1:0]  inv_w1, inv_w2, inv_w3;
    logic [WORD_W-1:0]  fwd_w0, fwd_w1, fwd_w2, fwd_w3;
    logic [WORD_W-1:0]  g_in, g_out;
    logic [CNT_W-1:0]   g_cnt;

    assign {w0, w1, w2, w3} = key_q;

    // Inverse step needs w3' before g, so the single g instance is muxed per state
    assign inv_w3 = w3 ^ w2;
    assign inv_w2 = w2 ^ w1;
    assign inv_w1 = w1 ^ w0;
    assign g_in   = (state_q == EMIT) ? inv_w3 : w3;
    assign g_cnt  = (state_q == EMIT) ? rnum_q - CNT_W'(1) : cnt_q;

    g_func_key_expansion u_g (
        .word_i  (g_in),
        .count_i (g_cnt),
        .g_c_o   (g_out)
    );

    assign fwd_w0 = w0 ^ g_out;
    assign fwd_w1 = w1 ^ fwd_w0;
    assign fwd_w2 = w2 ^ fwd_w1;
    assign fwd_w3 = w3 ^ fwd_w2;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            key_q   <= '0;
            cnt_q   <= '0;
            rnum_q  <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            cnt_q   <= cnt_d;
            rnum_q  <= rnum_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        cnt_d   = cnt_q;
        rnum_d  = rnum_q;
        case (state_q)
            IDLE: begin
                if (bus.key_load) begin
                    key_d   = bus.key_in;
                    cnt_d   = '0;
                    state_d = EXPAND;
                end
            end
            EXPAND: begin
                key_d = {fwd_w0, fwd_w1, fwd_w2, fwd_w3};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(LAST_CNT)) begin
                    state_d = EMIT;
                    rnum_d  = CNT_W'(NUM_ROUNDS);
                end
            end
            EMIT: begin
                if (bus.rk_ready) begin
                    if (rnum_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        key_d  = {fwd_w0, inv_w1, inv_w2, inv_w3};
                        rnum_d = rnum_q - CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d  = (state_d != IDLE);
        valid_d = (state_d == EMIT);
        last_d  = valid_d && (rnum_d == '0);
    end

    assign bus.busy      = busy_q;
    assign bus.rk_valid  = valid_q;
    assign bus.last      = last_q;
    assign bus.round_key = key_q;
    assign bus.round_num = rnum_q;
endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Directed + randomized bench for the inverse AES-128 key schedule against a
// FIPS-197 style full-expansion model built from GF(2^8) arithmetic.
module tb_aes_inv_key_schedule;
    logic clk;
    logic n_rst;
    int   n_cmp;
    int   n_err;

    logic [7:0]   sbox_m [256];
    logic [127:0] rk_exp [0:10];
    logic [127:0] obs_rk [0:10];

    localparam logic [127:0] KAT = 128'h2B7E151628AED2A6ABF7158809CF4F3C;

    aes_inv_key_schedule_if bus ();

    aes_inv_key_schedule dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] av;
        logic [7:0] bv;
        for (int a = 0; a < 256; a++) begin
            av  = 8'(a);
            inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                bv = 8'(b);
                if (gmul(av, bv) == 8'h01) inv = bv;
            end
            sbox_m[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic model_expand(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) rk_exp[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: ready always high, 1: 5-cycle stall then alternate, 2: random ready
    task automatic run_key(input logic [127:0] k, input int mode, input bit poke, input int stop_round);
        int cyc;
        int exp_r;
        int hs;
        int guard;
        bit rdy;
        bit done;
        model_expand(k);
        bus.key_in   = k;
        bus.key_load = 1'b1;
        bus.rk_ready = 1'b0;
        tick();
        bus.key_load = 1'b0;
        chk("busy_after_load", 128'(bus.busy), 128'(1));
        chk("valid_in_expand", 128'(bus.rk_valid), 128'(0));
        cyc = 0;
        while (!bus.rk_valid && cyc < 20) begin
            if (poke && cyc == 3) begin
                bus.key_in   = '0;
                bus.key_load = 1'b1;
            end
            tick();
            cyc++;
            bus.key_load = 1'b0;
            bus.key_in   = k;
        end
        chk("valid_latency", 128'(cyc), 128'(10));
        if (!bus.rk_valid) return;
        exp_r = 10;
        hs    = 0;
        guard = 0;
        done  = 1'b0;
        while (!done && guard < 200) begin
            guard++;
            chk("rk_valid", 128'(bus.rk_valid), 128'(1));
            chk("busy_emit", 128'(bus.busy), 128'(1));
            chk("round_num", 128'(bus.round_num), 128'(exp_r));
            chk("round_key", bus.round_key, rk_exp[exp_r]);
            chk("last", 128'(bus.last), 128'(exp_r == 0));
            obs_rk[exp_r] = bus.round_key;
            if (exp_r == stop_round) return;
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (guard > 5) && (guard % 2 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            bus.rk_ready = rdy;
            if (poke && (guard == 2 || exp_r == 0)) begin
                bus.key_in   = '0;
                bus.key_load = 1'b1;
            end
            tick();
            bus.key_load = 1'b0;
            bus.key_in   = k;
            if (rdy) begin
                hs++;
                if (exp_r == 0) done = 1'b1;
                else exp_r--;
            end
        end
        bus.rk_ready = 1'b0;
        chk("handshakes", 128'(hs), 128'(11));
        chk("busy_done", 128'(bus.busy), 128'(0));
        chk("valid_done", 128'(bus.rk_valid), 128'(0));
        chk("last_done", 128'(bus.last), 128'(0));
        chk("num_hold", 128'(bus.round_num), 128'(0));
        chk("key_hold", bus.round_key, rk_exp[0]);
    endtask

    task automatic chk_kat(input string tag);
        chk({tag, "_r10"}, obs_rk[10], 128'hD014F9A8C9EE2589E13F0CC8B6630CA6);
        chk({tag, "_r9"},  obs_rk[9],  128'hAC7766F319FADC2128D12941575C006E);
        chk({tag, "_r1"},  obs_rk[1],  128'hA0FAFE1788542CB123A339392A6C7605);
        chk({tag, "_r0"},  obs_rk[0],  KAT);
    endtask

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        n_rst        = 1'b0;
        bus.key_in   = '0;
        bus.key_load = 1'b0;
        bus.rk_ready = 1'b0;
        build_sbox();

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 128'(bus.busy), 128'(0));
        chk("rst_valid", 128'(bus.rk_valid), 128'(0));
        chk("rst_last", 128'(bus.last), 128'(0));
        chk("rst_num", 128'(bus.round_num), 128'(0));
        chk("rst_key", bus.round_key, 128'(0));
        @(negedge clk);
        n_rst = 1'b1;
        tick();

        // known answer, then back-to-back load with backpressure
        run_key(KAT, 0, 1'b0, -1);
        chk_kat("kat");
        run_key(KAT, 1, 1'b0, -1);
        chk_kat("bp");

        // loads during EXPAND, EMIT and on the final handshake must be ignored
        run_key(KAT, 0, 1'b1, -1);
        chk_kat("poke");

        // asynchronous reset while round 6 is presented
        run_key(KAT, 0, 1'b0, 6);
        #2;
        n_rst = 1'b0;
        #1;
        chk("arst_busy", 128'(bus.busy), 128'(0));
        chk("arst_valid", 128'(bus.rk_valid), 128'(0));
        chk("arst_last", 128'(bus.last), 128'(0));
        chk("arst_num", 128'(bus.round_num), 128'(0));
        chk("arst_key", bus.round_key, 128'(0));
        bus.rk_ready = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        tick();
        chk("arst_idle", 128'(bus.busy), 128'(0));
        run_key(KAT, 0, 1'b0, -1);
        chk_kat("after_rst");

        run_key(128'h0, 0, 1'b0, -1);
        chk("zero_r10", obs_rk[10], 128'hB4EF5BCB3E92E21123E951CF6F8F188E);
        chk("zero_r1",  obs_rk[1],  128'h62636363626363636263636362636363);
        chk("zero_r0",  obs_rk[0],  128'h0);

        repeat (4) begin
            run_key({$urandom, $urandom, $urandom, $urandom}, 2, 1'b0, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
